// File: rtl/axi4_region_pkg.sv
// Shared types for the region-table programming path: status codes, FSM states,
// shadow entry layout and the inclusive-range overlap test.
package axi4_region_pkg;

  localparam int unsigned PAGE_BITS      = 12;
  localparam int unsigned MAX_ADDR_WIDTH = 64;

  typedef enum logic [2:0] {
    OK          = 3'd0,
    ERR_ID      = 3'd1,
    ERR_ALIGN   = 3'd2,
    ERR_OVERLAP = 3'd3,
    ERR_VERIFY  = 3'd4
  } region_status_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT,
    ST_VERIFY_LO,
    ST_VERIFY_HI,
    ST_RESP
  } cfg_state_e;

  // Addresses are stored at the widest supported width and zero-extended on write.
  typedef struct packed {
    logic                      enable;
    logic [MAX_ADDR_WIDTH-1:0] start_addr;
    logic [MAX_ADDR_WIDTH-1:0] end_addr;
  } region_entry_t;

  function automatic logic regions_overlap(
    input logic [MAX_ADDR_WIDTH-1:0] a_start,
    input logic [MAX_ADDR_WIDTH-1:0] a_end,
    input logic [MAX_ADDR_WIDTH-1:0] b_start,
    input logic [MAX_ADDR_WIDTH-1:0] b_end
  );
    return !((a_end < b_start) || (a_start > b_end));
  endfunction

endpackage

// File: rtl/axi4_region_cfg_master.sv
// Programs one axi4_region_decoder entry per request: pre-checks against a shadow
// table, strobes the cfg port, reads both range ends back, then returns a status.
module axi4_region_cfg_master
  import axi4_region_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned NUM_REGIONS  = 16,
  parameter int unsigned REGION_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [REGION_WIDTH-1:0] req_region_id,
  input  logic [ADDR_WIDTH-1:0]   req_start_addr,
  input  logic [ADDR_WIDTH-1:0]   req_end_addr,
  input  logic                    req_enable,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2:0]              rsp_status,
  output logic                    cfg_valid,
  output logic [REGION_WIDTH-1:0] cfg_region_id,
  output logic [ADDR_WIDTH-1:0]   cfg_start_addr,
  output logic [ADDR_WIDTH-1:0]   cfg_end_addr,
  output logic                    cfg_enable,
  output logic                    decode_valid,
  output logic [ADDR_WIDTH-1:0]   decode_addr,
  input  logic [REGION_WIDTH-1:0] decode_region,
  input  logic                    decode_hit,
  input  logic                    decode_error,
  output logic                    busy
);

  cfg_state_e               state_q, state_d;
  logic [REGION_WIDTH-1:0]  idx_q, idx_d;
  region_status_e           status_q, status_d;
  logic                     vfail_q, vfail_d;
  logic                     accept;

  logic [REGION_WIDTH-1:0]  lat_id;
  logic [ADDR_WIDTH-1:0]    lat_start;
  logic [ADDR_WIDTH-1:0]    lat_end;
  logic                     lat_enable;

  region_entry_t            shadow [NUM_REGIONS];
  region_entry_t            cur_entry;
  logic                     id_bad, align_bad, entry_hit, probe_bad;

  assign cur_entry = shadow[idx_q];
  assign id_bad    = ({1'b0, req_region_id} >= (REGION_WIDTH+1)'(NUM_REGIONS));
  assign align_bad = (req_start_addr > req_end_addr) ||
                     (req_start_addr[PAGE_BITS-1:0] != '0) ||
                     (req_end_addr[PAGE_BITS-1:0] != '1);
  // Own entry, disabled entries and disable requests never conflict.
  assign entry_hit = lat_enable && cur_entry.enable && (idx_q != lat_id) &&
                     regions_overlap(MAX_ADDR_WIDTH'(lat_start), MAX_ADDR_WIDTH'(lat_end),
                                     cur_entry.start_addr, cur_entry.end_addr);
  assign probe_bad = !decode_hit || decode_error || (decode_region != lat_id);

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    status_d = status_q;
    vfail_d  = vfail_q;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          vfail_d = 1'b0;
          if (id_bad) begin
            status_d = ERR_ID;
            state_d  = ST_RESP;
          end else if (align_bad) begin
            status_d = ERR_ALIGN;
            state_d  = ST_RESP;
          end else begin
            status_d = OK;
            state_d  = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (entry_hit) begin
          status_d = ERR_OVERLAP;
          state_d  = ST_RESP;
        end else if (idx_q == REGION_WIDTH'(NUM_REGIONS - 1)) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q + REGION_WIDTH'(1);
        end
      end
      ST_COMMIT:    state_d = lat_enable ? ST_VERIFY_LO : ST_RESP;
      ST_VERIFY_LO: begin
        vfail_d = probe_bad;
        state_d = ST_VERIFY_HI;
      end
      ST_VERIFY_HI: begin
        if (vfail_q || probe_bad) status_d = ERR_VERIFY;
        state_d = ST_RESP;
      end
      ST_RESP:      if (rsp_ready) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State, descriptor latch and shadow table
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      status_q   <= OK;
      vfail_q    <= 1'b0;
      lat_id     <= '0;
      lat_start  <= '0;
      lat_end    <= '0;
      lat_enable <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) shadow[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      status_q <= status_d;
      vfail_q  <= vfail_d;
      if (accept) begin
        lat_id     <= req_region_id;
        lat_start  <= req_start_addr;
        lat_end    <= req_end_addr;
        lat_enable <= req_enable;
      end
      if (state_q == ST_COMMIT) begin
        shadow[lat_id] <= '{enable:     lat_enable,
                            start_addr: MAX_ADDR_WIDTH'(lat_start),
                            end_addr:   MAX_ADDR_WIDTH'(lat_end)};
      end
    end
  end

  // Outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready      <= 1'b1;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_status     <= 3'(OK);
      cfg_valid      <= 1'b0;
      cfg_region_id  <= '0;
      cfg_start_addr <= '0;
      cfg_end_addr   <= '0;
      cfg_enable     <= 1'b0;
      decode_valid   <= 1'b0;
      decode_addr    <= '0;
    end else begin
      req_ready      <= (state_d == ST_IDLE);
      busy           <= (state_d != ST_IDLE);
      rsp_valid      <= (state_d == ST_RESP);
      rsp_status     <= (state_d == ST_RESP) ? 3'(status_d) : 3'(OK);
      cfg_valid      <= (state_d == ST_COMMIT);
      cfg_region_id  <= (state_d == ST_COMMIT) ? lat_id     : '0;
      cfg_start_addr <= (state_d == ST_COMMIT) ? lat_start  : '0;
      cfg_end_addr   <= (state_d == ST_COMMIT) ? lat_end    : '0;
      cfg_enable     <= (state_d == ST_COMMIT) ? lat_enable : 1'b0;
      decode_valid   <= (state_d == ST_VERIFY_LO) || (state_d == ST_VERIFY_HI);
      decode_addr    <= (state_d == ST_VERIFY_LO) ? lat_start :
                        (state_d == ST_VERIFY_HI) ? lat_end   : '0;
    end
  end

endmodule

// File: tb/tb_axi4_region_cfg_master.sv
// Bench for axi4_region_cfg_master with a behavioural region decoder attached and a
// second small instance (8 regions) for the id range check.
module tb_axi4_region_cfg_master;
  import axi4_region_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned NR = 16;
  localparam int unsigned RW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_ready, req_enable;
  logic [RW-1:0] req_region_id;
  logic [AW-1:0] req_start_addr, req_end_addr;
  logic          rsp_valid, rsp_ready;
  logic [2:0]    rsp_status;
  logic          cfg_valid, cfg_enable;
  logic [RW-1:0] cfg_region_id;
  logic [AW-1:0] cfg_start_addr, cfg_end_addr;
  logic          decode_valid;
  logic [AW-1:0] decode_addr;
  logic [RW-1:0] decode_region;
  logic          decode_hit, decode_error;
  logic          busy;

  axi4_region_cfg_master #(.ADDR_WIDTH(AW), .NUM_REGIONS(NR), .REGION_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_region_id(req_region_id),
    .req_start_addr(req_start_addr), .req_end_addr(req_end_addr), .req_enable(req_enable),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .cfg_valid(cfg_valid), .cfg_region_id(cfg_region_id), .cfg_start_addr(cfg_start_addr),
    .cfg_end_addr(cfg_end_addr), .cfg_enable(cfg_enable),
    .decode_valid(decode_valid), .decode_addr(decode_addr), .decode_region(decode_region),
    .decode_hit(decode_hit), .decode_error(decode_error), .busy(busy)
  );

  // Second instance: 8-entry table, decoder inputs tied off
  logic          r8_req_valid, r8_req_ready, r8_req_enable, r8_rsp_valid, r8_rsp_ready;
  logic [RW-1:0] r8_req_id, r8_cfg_id, r8_dec_region;
  logic [AW-1:0] r8_req_start, r8_req_end, r8_cfg_start, r8_cfg_end, r8_dec_addr;
  logic [2:0]    r8_rsp_status;
  logic          r8_cfg_valid, r8_cfg_enable, r8_dec_valid, r8_dec_hit, r8_dec_error, r8_busy;

  axi4_region_cfg_master #(.ADDR_WIDTH(AW), .NUM_REGIONS(8), .REGION_WIDTH(RW)) dut8 (
    .clk(clk), .rst(rst),
    .req_valid(r8_req_valid), .req_ready(r8_req_ready), .req_region_id(r8_req_id),
    .req_start_addr(r8_req_start), .req_end_addr(r8_req_end), .req_enable(r8_req_enable),
    .rsp_valid(r8_rsp_valid), .rsp_ready(r8_rsp_ready), .rsp_status(r8_rsp_status),
    .cfg_valid(r8_cfg_valid), .cfg_region_id(r8_cfg_id), .cfg_start_addr(r8_cfg_start),
    .cfg_end_addr(r8_cfg_end), .cfg_enable(r8_cfg_enable),
    .decode_valid(r8_dec_valid), .decode_addr(r8_dec_addr), .decode_region(r8_dec_region),
    .decode_hit(r8_dec_hit), .decode_error(r8_dec_error), .busy(r8_busy)
  );

  // Behavioural decoder: lowest matching enabled entry wins, >1 match flags error
  logic          dec_en [NR];
  logic [AW-1:0] dec_s  [NR];
  logic [AW-1:0] dec_e  [NR];
  logic          stub_bad;
  logic [RW-1:0] m_region;
  logic          m_hit;
  int            m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        dec_en[i] <= 1'b0; dec_s[i] <= '0; dec_e[i] <= '0;
      end
    end else if (cfg_valid) begin
      dec_en[cfg_region_id] <= cfg_enable;
      dec_s[cfg_region_id]  <= cfg_start_addr;
      dec_e[cfg_region_id]  <= cfg_end_addr;
    end
  end

  always_comb begin
    m_region = '0;
    m_hit    = 1'b0;
    m_cnt    = 0;
    for (int i = 0; i < NR; i++) begin
      if (dec_en[i] && decode_addr >= dec_s[i] && decode_addr <= dec_e[i]) begin
        if (!m_hit) m_region = RW'(i);
        m_hit = 1'b1;
        m_cnt++;
      end
    end
  end

  assign decode_region = stub_bad ? RW'(5) : m_region;
  assign decode_hit    = m_hit;
  assign decode_error  = (m_cnt > 1);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [RW-1:0] id;
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    logic          en;
    logic [2:0]    status;
    int            lat;
    int            ncfg;
    int            nprobe;
  } exp_t;

  exp_t sb_q[$];

  int         cyc = 0, t0 = 0, cfg_cnt = 0, probe_cnt = 0, done_cnt = 0;
  bit         rsp_seen = 0;
  logic [2:0] last_status;

  // Monitor: samples on the falling edge, pops the scoreboard on the first response cycle
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rsp_seen = 0;
    end else begin
      if (req_valid && req_ready) begin
        t0 = cyc; cfg_cnt = 0; probe_cnt = 0; rsp_seen = 0;
      end
      if (cfg_valid && decode_valid) chk("cfg_decode_overlap", 1, 0);
      if (cfg_valid) begin
        cfg_cnt++;
        if (sb_q.size() == 0) chk("cfg_unexpected", 1, 0);
        else begin
          chk("cfg_cycle", 64'(cyc - t0), 64'(NR + 1));
          chk("cfg_id",    64'(cfg_region_id),  64'(sb_q[0].id));
          chk("cfg_start", 64'(cfg_start_addr), 64'(sb_q[0].s));
          chk("cfg_end",   64'(cfg_end_addr),   64'(sb_q[0].e));
          chk("cfg_en",    64'(cfg_enable),     64'(sb_q[0].en));
        end
      end
      if (decode_valid) begin
        probe_cnt++;
        if (sb_q.size() == 0) chk("probe_unexpected", 1, 0);
        else chk("probe_addr", 64'(decode_addr),
                 (probe_cnt == 1) ? 64'(sb_q[0].s) : 64'(sb_q[0].e));
      end
      if (rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          last_status = rsp_status;
          if (sb_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            exp_t x;
            x = sb_q.pop_front();
            chk("rsp_status", 64'(rsp_status), 64'(x.status));
            chk("rsp_cycle",  64'(cyc - t0),   64'(x.lat));
            chk("cfg_pulses", 64'(cfg_cnt),    64'(x.ncfg));
            chk("probes",     64'(probe_cnt),  64'(x.nprobe));
          end
        end else begin
          chk("rsp_stable", 64'(rsp_status), 64'(last_status));
        end
        if (rsp_ready) done_cnt++;
      end
    end
  end

  task automatic run_txn(input logic [RW-1:0] id, input logic [AW-1:0] s, input logic [AW-1:0] e,
                         input logic en, input logic [2:0] st, input int lat,
                         input int ncfg, input int nprobe, input int hold);
    exp_t x;
    int   start_done, held;
    bit   got;
    x = '{id: id, s: s, e: e, en: en, status: st, lat: lat, ncfg: ncfg, nprobe: nprobe};
    sb_q.push_back(x);
    start_done = done_cnt;
    held = 0;
    got = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_region_id = id; req_start_addr = s; req_end_addr = e; req_enable = en;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int w = 0; w < 60; w++) begin
      if (done_cnt != start_done) begin got = 1; break; end
      if (rsp_valid && !rsp_ready) begin
        held++;
        if (held > hold) rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      chk("rsp_timeout", 0, 1);
      sb_q.delete();
    end
    rsp_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),      1);
    chk({tag, "_busy"},       64'(busy),           0);
    chk({tag, "_rsp_valid"},  64'(rsp_valid),      0);
    chk({tag, "_rsp_status"}, 64'(rsp_status),     0);
    chk({tag, "_cfg_valid"},  64'(cfg_valid),      0);
    chk({tag, "_cfg_fields"}, 64'({cfg_region_id, cfg_start_addr, cfg_end_addr, cfg_enable}) , 0);
    chk({tag, "_dec_valid"},  64'(decode_valid),   0);
    chk({tag, "_dec_addr"},   64'(decode_addr),    0);
  endtask

  initial begin
    logic [RW-1:0] bad_ids [2];
    rst = 1'b1; stub_bad = 1'b0;
    req_valid = 1'b0; req_region_id = '0; req_start_addr = '0; req_end_addr = '0; req_enable = 1'b0;
    rsp_ready = 1'b1;
    r8_req_valid = 1'b0; r8_req_id = '0; r8_req_start = '0; r8_req_end = '0; r8_req_enable = 1'b1;
    r8_rsp_ready = 1'b1; r8_dec_region = '0; r8_dec_hit = 1'b0; r8_dec_error = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Id range on the 8-entry instance; ERR_ID outranks a misaligned start
    bad_ids[0] = RW'(8);
    bad_ids[1] = RW'(9);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      r8_req_valid = 1'b1; r8_req_id = bad_ids[k];
      r8_req_start = 32'h0000_1800; r8_req_end = 32'h0000_1FFF;
      @(posedge clk); #1 r8_req_valid = 1'b0;
      @(negedge clk);
      chk("r8_rsp_valid",  64'(r8_rsp_valid),  1);
      chk("r8_rsp_status", 64'(r8_rsp_status), 64'(ERR_ID));
      chk("r8_cfg_valid",  64'(r8_cfg_valid),  0);
      @(posedge clk);
    end

    run_txn(4'd2, 32'h0000_1000, 32'h0000_1FFF, 1'b1, OK,          NR + 4, 1, 2, 0);
    run_txn(4'd4, 32'h0000_1800, 32'h0000_1FFF, 1'b1, ERR_ALIGN,   1,      0, 0, 0);
    run_txn(4'd3, 32'h0000_1000, 32'h0000_2FFF, 1'b1, ERR_OVERLAP, 4,      0, 0, 0);
    run_txn(4'd2, 32'h0000_1000, 32'h0000_3FFF, 1'b1, OK,          NR + 4, 1, 2, 0);
    run_txn(4'd5, 32'h0000_1000, 32'h0000_1FFF, 1'b0, OK,          NR + 2, 1, 0, 0);
    run_txn(4'd6, 32'h0000_4000, 32'h0000_4FFF, 1'b1, OK,          NR + 4, 1, 2, 0);
    run_txn(4'd8, 32'h0000_3000, 32'h0000_3FFF, 1'b1, ERR_OVERLAP, 4,      0, 0, 0);
    run_txn(4'd4, 32'h0000_5000, 32'h0000_5FFE, 1'b1, ERR_ALIGN,   1,      0, 0, 0);
    run_txn(4'd4, 32'h0000_6000, 32'h0000_5FFF, 1'b1, ERR_ALIGN,   1,      0, 0, 0);
    run_txn(4'd7, 32'hFFFF_F000, 32'hFFFF_FFFF, 1'b1, OK,          NR + 4, 1, 2, 0);

    // Decoder reports the wrong region: entry is still written, so a later overlap sees it
    stub_bad = 1'b1;
    run_txn(4'd9, 32'h0000_8000, 32'h0000_8FFF, 1'b1, ERR_VERIFY,  NR + 4, 1, 2, 5);
    stub_bad = 1'b0;
    run_txn(4'd10, 32'h0000_8000, 32'h0000_8FFF, 1'b1, ERR_OVERLAP, 11,    0, 0, 0);

    // Reset in the middle of the table scan
    @(posedge clk); #1;
    req_valid = 1'b1; req_region_id = 4'd11; req_start_addr = 32'h0000_A000;
    req_end_addr = 32'h0000_AFFF; req_enable = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");

    // Shadow was cleared, so the old id6 range no longer conflicts
    run_txn(4'd2,  32'h0000_1000, 32'h0000_1FFF, 1'b1, OK, NR + 4, 1, 2, 0);
    run_txn(4'd11, 32'h0000_4000, 32'h0000_4FFF, 1'b1, OK, NR + 4, 1, 2, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
